// File: rtl/pit_bus_sequencer.sv
// Bus master for the 8253 CPU port: turns single program / latch-and-read
// commands into ordered control-word and LSB/MSB accesses with programmable timing.
module pit_bus_sequencer #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [1:0]  cmd_chan,
    input  logic [1:0]  cmd_rw,
    input  logic [2:0]  cmd_mode,
    input  logic        cmd_bcd,
    input  logic [15:0] cmd_count,
    output logic        done,
    output logic        err,
    output logic [15:0] rd_count,
    output logic        busy,
    output logic        pit_cs_n,
    output logic        pit_rd_n,
    output logic        pit_wr_n,
    output logic        pit_a1,
    output logic        pit_a0,
    output logic [7:0]  pit_d_out,
    output logic        pit_d_oe,
    input  logic [7:0]  pit_d_in
);
    // state  | meaning
    // IDLE   | ready for a command
    // CTRL   | control-word write to address 3
    // B0     | first data access (gap, setup, strobe, hold)
    // B1     | second data access, two-byte transfers only
    // DONE   | one-cycle completion pulse, err if the command was illegal
    typedef enum logic [2:0] {S_IDLE, S_CTRL, S_B0, S_B1, S_DONE} state_t;
    typedef enum logic [1:0] {PH_GAP, PH_SETUP, PH_STROBE, PH_HOLD} phase_t;

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        op_q, bcd_q, err_q;
    logic [1:0]  chan_q, rw_q;
    logic [2:0]  mode_q;
    logic [15:0] count_q, rd_count_q;
    logic [7:0]  lsb_q, msb_q;

    logic        accept, illegal, two_bytes, in_access, is_write, sample;
    logic [7:0]  ctrl_word;

    assign accept    = cmd_valid && (state_q == S_IDLE);
    assign illegal   = (cmd_chan == 2'd3) || (!cmd_op && (cmd_rw == 2'b00));
    // A read with rw = 00 still fetches both bytes.
    assign two_bytes = (rw_q == 2'b11) || (op_q && (rw_q == 2'b00));
    assign in_access = ((state_q == S_CTRL) || (state_q == S_B0) || (state_q == S_B1))
                       && (phase_q != PH_GAP);
    assign is_write  = (state_q == S_CTRL) || !op_q;
    assign sample    = in_access && !is_write && (phase_q == PH_STROBE) && (cnt_q == 4'd0);
    assign ctrl_word = op_q ? {chan_q, 6'b000000} : {chan_q, rw_q, mode_q, bcd_q};

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (illegal) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CTRL;
                        phase_d = PH_SETUP;
                        cnt_d   = SETUP_LD;
                    end
                end
            end
            S_CTRL, S_B0, S_B1: begin
                case (phase_q)
                    PH_GAP: begin
                        phase_d = PH_SETUP;
                        cnt_d   = SETUP_LD;
                    end
                    PH_SETUP: begin
                        if (cnt_q == 4'd0) begin
                            phase_d = PH_STROBE;
                            cnt_d   = STROBE_LD;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                    PH_STROBE: begin
                        if (cnt_q == 4'd0) begin
                            phase_d = PH_HOLD;
                            cnt_d   = HOLD_LD;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                    PH_HOLD: begin
                        if (cnt_q == 4'd0) begin
                            phase_d = PH_GAP;
                            if (state_q == S_CTRL)
                                state_d = S_B0;
                            else if ((state_q == S_B0) && two_bytes)
                                state_d = S_B1;
                            else
                                state_d = S_DONE;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                    default: phase_d = PH_GAP;
                endcase
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            phase_q    <= PH_GAP;
            cnt_q      <= '0;
            op_q       <= 1'b0;
            chan_q     <= '0;
            rw_q       <= '0;
            mode_q     <= '0;
            bcd_q      <= 1'b0;
            count_q    <= '0;
            err_q      <= 1'b0;
            lsb_q      <= '0;
            msb_q      <= '0;
            rd_count_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q    <= cmd_op;
                chan_q  <= cmd_chan;
                rw_q    <= cmd_rw;
                mode_q  <= cmd_mode;
                bcd_q   <= cmd_bcd;
                count_q <= cmd_count;
                err_q   <= illegal;
            end
            // A lone MSB read lands in B0, so the byte slot follows rw as well as position.
            if (sample) begin
                if ((state_q == S_B1) || (rw_q == 2'b10))
                    msb_q <= pit_d_in;
                else
                    lsb_q <= pit_d_in;
            end
            if (op_q && ((state_q == S_B0) || (state_q == S_B1)) && (state_d == S_DONE)) begin
                case (rw_q)
                    2'b01:   rd_count_q <= {8'h00, lsb_q};
                    2'b10:   rd_count_q <= {msb_q, 8'h00};
                    default: rd_count_q <= {msb_q, lsb_q};
                endcase
            end
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = !cmd_ready;
    assign done      = (state_q == S_DONE);
    assign err       = done && err_q;
    assign rd_count  = rd_count_q;
    assign pit_cs_n  = !in_access;
    assign pit_wr_n  = !(in_access && is_write && (phase_q == PH_STROBE));
    assign pit_rd_n  = !(in_access && !is_write && (phase_q == PH_STROBE));
    assign pit_d_oe  = in_access && is_write;

    always_comb begin
        {pit_a1, pit_a0} = 2'b00;
        pit_d_out        = 8'h00;
        if (in_access)
            {pit_a1, pit_a0} = (state_q == S_CTRL) ? 2'b11 : chan_q;
        if (pit_d_oe) begin
            if (state_q == S_CTRL)
                pit_d_out = ctrl_word;
            else if ((state_q == S_B1) || (rw_q == 2'b10))
                pit_d_out = count_q[15:8];
            else
                pit_d_out = count_q[7:0];
        end
    end
endmodule

// File: tb/tb_pit_bus_sequencer.sv
// Bench for pit_bus_sequencer: a command table plus hand sequences; a bus monitor
// pops expected 8253 accesses from a scoreboard queue and checks data and timing.
module tb_pit_bus_sequencer;
    typedef struct {
        logic        op;
        logic [1:0]  chan;
        logic [1:0]  rw;
        logic [2:0]  mode;
        logic        bcd;
        logic [15:0] count;
        logic [7:0]  ctrl;
        int          lat;
        logic        err;
        logic [15:0] rdval;
        logic [15:0] exp_rd;
    } vec_t;

    typedef struct {
        logic       rd;
        logic [1:0] addr;
        logic [7:0] data;
        logic       first;
    } acc_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        cmd_valid [2];
    logic        cmd_ready [2];
    logic        cmd_op [2];
    logic [1:0]  cmd_chan [2];
    logic [1:0]  cmd_rw [2];
    logic [2:0]  cmd_mode [2];
    logic        cmd_bcd [2];
    logic [15:0] cmd_count [2];
    logic        done [2];
    logic        err [2];
    logic [15:0] rd_count [2];
    logic        busy [2];
    logic        pit_cs_n [2];
    logic        pit_rd_n [2];
    logic        pit_wr_n [2];
    logic        pit_a1 [2];
    logic        pit_a0 [2];
    logic [7:0]  pit_d_out [2];
    logic        pit_d_oe [2];
    logic [7:0]  pit_d_in [2];

    pit_bus_sequencer dut0 (
        .clk(clk), .rst(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_op(cmd_op[0]), .cmd_chan(cmd_chan[0]), .cmd_rw(cmd_rw[0]), .cmd_mode(cmd_mode[0]),
        .cmd_bcd(cmd_bcd[0]), .cmd_count(cmd_count[0]), .done(done[0]), .err(err[0]),
        .rd_count(rd_count[0]), .busy(busy[0]), .pit_cs_n(pit_cs_n[0]), .pit_rd_n(pit_rd_n[0]),
        .pit_wr_n(pit_wr_n[0]), .pit_a1(pit_a1[0]), .pit_a0(pit_a0[0]), .pit_d_out(pit_d_out[0]),
        .pit_d_oe(pit_d_oe[0]), .pit_d_in(pit_d_in[0])
    );

    pit_bus_sequencer #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(1)) dut1 (
        .clk(clk), .rst(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_op(cmd_op[1]), .cmd_chan(cmd_chan[1]), .cmd_rw(cmd_rw[1]), .cmd_mode(cmd_mode[1]),
        .cmd_bcd(cmd_bcd[1]), .cmd_count(cmd_count[1]), .done(done[1]), .err(err[1]),
        .rd_count(rd_count[1]), .busy(busy[1]), .pit_cs_n(pit_cs_n[1]), .pit_rd_n(pit_rd_n[1]),
        .pit_wr_n(pit_wr_n[1]), .pit_a1(pit_a1[1]), .pit_a0(pit_a0[1]), .pit_d_out(pit_d_out[1]),
        .pit_d_oe(pit_d_oe[1]), .pit_d_in(pit_d_in[1])
    );

    int n_vec = 0;
    int n_fail = 0;

    acc_t       exp_q [2][$];
    logic [7:0] feed_q [2][$];

    bit         mon_en = 1'b0;
    bit         overlap_seen = 1'b0;
    bit         abort [2];
    logic       prev_cs [2];
    int         n_setup [2];
    int         n_strobe [2];
    int         n_hold [2];
    int         gap_cnt [2];
    int         acc_gap [2];
    logic       acc_rd [2];
    logic       oe_any [2];
    logic       oe_all [2];
    logic       stable [2];
    logic [1:0] acc_addr [2];
    logic [7:0] acc_data [2];

    function automatic int set_len(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic int str_len(input int k);
        return (k == 0) ? 2 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic finish_access(input int k);
        acc_t e;
        if (abort[k]) begin
            abort[k] = 1'b0;
        end else begin
            check($sformatf("dut%0d_access_expected", k), exp_q[k].size() > 0, 1);
            if (exp_q[k].size() > 0) begin
                e = exp_q[k].pop_front();
                check($sformatf("dut%0d_kind_addr", k), {acc_rd[k], acc_addr[k]}, {e.rd, e.addr});
                if (!e.rd)
                    check($sformatf("dut%0d_wdata", k), acc_data[k], e.data);
                check($sformatf("dut%0d_timing", k),
                      {8'(n_setup[k]), 8'(n_strobe[k]), 8'(n_hold[k])},
                      {8'(set_len(k)), 8'(str_len(k)), 8'd1});
                check($sformatf("dut%0d_oe", k), {oe_any[k], oe_all[k]}, e.rd ? 2'b00 : 2'b11);
                check($sformatf("dut%0d_stable", k), stable[k], 1);
                if (!e.first)
                    check($sformatf("dut%0d_gap", k), acc_gap[k], 1);
                if (e.rd && (feed_q[k].size() > 0))
                    void'(feed_q[k].pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                if (!pit_rd_n[k] && !pit_wr_n[k])
                    overlap_seen = 1'b1;
                if (!pit_cs_n[k]) begin
                    if (prev_cs[k]) begin
                        n_setup[k] = 0; n_strobe[k] = 0; n_hold[k] = 0;
                        acc_rd[k] = 1'b0; oe_any[k] = 1'b0; oe_all[k] = 1'b1; stable[k] = 1'b1;
                        acc_addr[k] = {pit_a1[k], pit_a0[k]};
                        acc_data[k] = pit_d_out[k];
                        acc_gap[k] = gap_cnt[k];
                    end
                    if ({pit_a1[k], pit_a0[k]} != acc_addr[k])
                        stable[k] = 1'b0;
                    if (pit_d_oe[k] && (pit_d_out[k] != acc_data[k]))
                        stable[k] = 1'b0;
                    if (pit_d_oe[k]) oe_any[k] = 1'b1;
                    else             oe_all[k] = 1'b0;
                    if (!pit_rd_n[k] || !pit_wr_n[k]) begin
                        n_strobe[k]++;
                        if (!pit_rd_n[k]) acc_rd[k] = 1'b1;
                    end else if (n_strobe[k] == 0) begin
                        n_setup[k]++;
                    end else begin
                        n_hold[k]++;
                    end
                end else if (!prev_cs[k]) begin
                    finish_access(k);
                    gap_cnt[k] = 1;
                end else begin
                    gap_cnt[k]++;
                end
                // Read data is only valid in the last strobe cycle, like a slow 8253 access.
                pit_d_in[k] = (!pit_rd_n[k] && (n_strobe[k] == str_len(k)) && (feed_q[k].size() > 0))
                              ? feed_q[k][0] : 8'hA5;
                prev_cs[k] = pit_cs_n[k];
            end
        end
    end

    task automatic drive_fields(input int k, input vec_t v);
        cmd_op[k]    = v.op;
        cmd_chan[k]  = v.chan;
        cmd_rw[k]    = v.rw;
        cmd_mode[k]  = v.mode;
        cmd_bcd[k]   = v.bcd;
        cmd_count[k] = v.count;
    endtask

    task automatic scramble(input int k);
        cmd_op[k]    = ~cmd_op[k];
        cmd_chan[k]  = ~cmd_chan[k];
        cmd_rw[k]    = ~cmd_rw[k];
        cmd_mode[k]  = ~cmd_mode[k];
        cmd_bcd[k]   = ~cmd_bcd[k];
        cmd_count[k] = ~cmd_count[k];
    endtask

    task automatic push_byte(input int k, input logic rd, input logic [1:0] addr, input logic [7:0] b);
        acc_t a;
        a = '{rd: rd, addr: addr, data: b, first: 1'b0};
        exp_q[k].push_back(a);
        if (rd) feed_q[k].push_back(b);
    endtask

    task automatic push_expect(input int k, input vec_t v);
        acc_t a;
        if (!v.err) begin
            a = '{rd: 1'b0, addr: 2'd3, data: v.ctrl, first: 1'b1};
            exp_q[k].push_back(a);
            if (v.rw != 2'b10)
                push_byte(k, v.op, v.chan, v.op ? v.rdval[7:0] : v.count[7:0]);
            if (v.rw != 2'b01)
                push_byte(k, v.op, v.chan, v.op ? v.rdval[15:8] : v.count[15:8]);
        end
    endtask

    task automatic accept(input int k, input bit keep);
        @(negedge clk);
        cmd_valid[k] = 1'b1;
        check($sformatf("dut%0d_ready_before_accept", k), cmd_ready[k], 1);
        @(posedge clk);
        #1;
        if (!keep) begin
            cmd_valid[k] = 1'b0;
            scramble(k);
        end
    endtask

    task automatic wait_done(input int k, input int lat, input logic e_err,
                             input logic [15:0] e_rd, input string tag);
        int  n;
        bit  seen;
        n = 0;
        seen = 1'b0;
        for (int i = 1; (i <= 60) && !seen; i++) begin
            @(negedge clk);
            if ((i == 1) && (lat > 1))
                check({tag, "_busy"}, {busy[k], cmd_ready[k]}, 2'b10);
            if (done[k]) begin
                seen = 1'b1;
                n = i;
            end
        end
        check({tag, "_latency"}, n, lat);
        if (seen) begin
            check({tag, "_err"}, err[k], e_err);
            check({tag, "_rd_count"}, rd_count[k], e_rd);
        end
        @(negedge clk);
        check({tag, "_pulse_ready"}, {done[k], err[k], cmd_ready[k]}, 3'b001);
        check({tag, "_drained"}, exp_q[k].size(), 0);
    endtask

    vec_t tbl [12];
    vec_t d1a, d1b;
    int   nwr;
    bit   hit, prev_wr, seen_done;

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; cmd_valid[k] = 1'b0; cmd_op[k] = 1'b0; cmd_chan[k] = '0; cmd_rw[k] = '0;
            cmd_mode[k] = '0; cmd_bcd[k] = 1'b0; cmd_count[k] = '0; pit_d_in[k] = 8'hA5;
            abort[k] = 1'b0; prev_cs[k] = 1'b1; gap_cnt[k] = 0; n_strobe[k] = 0;
        end
        //            op    chan  rw     mode  bcd   count     ctrl   lat err   rdval     exp_rd
        tbl[0]  = '{1'b0, 2'd0, 2'b11, 3'd3, 1'b0, 16'h1234, 8'h36, 15, 1'b0, 16'h0000, 16'h0000};
        tbl[1]  = '{1'b0, 2'd1, 2'b01, 3'd2, 1'b0, 16'h0012, 8'h54, 10, 1'b0, 16'h0000, 16'h0000};
        tbl[2]  = '{1'b0, 2'd2, 2'b11, 3'd0, 1'b0, 16'h0400, 8'hB0, 15, 1'b0, 16'h0000, 16'h0000};
        tbl[3]  = '{1'b1, 2'd2, 2'b11, 3'd0, 1'b0, 16'h0000, 8'h80, 15, 1'b0, 16'h03FF, 16'h03FF};
        tbl[4]  = '{1'b1, 2'd1, 2'b01, 3'd0, 1'b0, 16'h0000, 8'h40, 10, 1'b0, 16'h1277, 16'h0077};
        tbl[5]  = '{1'b1, 2'd0, 2'b10, 3'd5, 1'b1, 16'hFFFF, 8'h00, 10, 1'b0, 16'h5A33, 16'h5A00};
        tbl[6]  = '{1'b1, 2'd2, 2'b00, 3'd0, 1'b0, 16'h0000, 8'h80, 15, 1'b0, 16'h1BCD, 16'h1BCD};
        tbl[7]  = '{1'b0, 2'd3, 2'b11, 3'd3, 1'b0, 16'h1111, 8'h00,  1, 1'b1, 16'h0000, 16'h1BCD};
        tbl[8]  = '{1'b0, 2'd0, 2'b00, 3'd3, 1'b0, 16'h2222, 8'h00,  1, 1'b1, 16'h0000, 16'h1BCD};
        tbl[9]  = '{1'b1, 2'd3, 2'b01, 3'd0, 1'b0, 16'h0000, 8'h00,  1, 1'b1, 16'h7777, 16'h1BCD};
        tbl[10] = '{1'b0, 2'd1, 2'b10, 3'd5, 1'b1, 16'hABCD, 8'h6B, 10, 1'b0, 16'h0000, 16'h1BCD};
        tbl[11] = '{1'b0, 2'd0, 2'b01, 3'd4, 1'b1, 16'h0099, 8'h19, 10, 1'b0, 16'h0000, 16'h1BCD};
        d1a     = '{1'b0, 2'd2, 2'b10, 3'd0, 1'b0, 16'hBEEF, 8'hA0, 14, 1'b0, 16'h0000, 16'h0000};
        d1b     = '{1'b1, 2'd1, 2'b11, 3'd0, 1'b0, 16'h0000, 8'h40, 21, 1'b0, 16'h4321, 16'h4321};

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("dut%0d_reset_ctl", k),
                  {cmd_ready[k], busy[k], done[k], err[k], pit_cs_n[k], pit_rd_n[k], pit_wr_n[k],
                   pit_a1[k], pit_a0[k], pit_d_oe[k]}, 10'b1000111000);
            check($sformatf("dut%0d_reset_data", k), {rd_count[k], pit_d_out[k]}, 24'h0);
            rst[k] = 1'b0;
        end
        mon_en = 1'b1;

        for (int i = 0; i < 12; i++) begin
            push_expect(0, tbl[i]);
            drive_fields(0, tbl[i]);
            accept(0, 1'b0);
            wait_done(0, tbl[i].lat, tbl[i].err, tbl[i].exp_rd, $sformatf("v%0d", i));
        end

        // Second command held valid throughout the first; it must wait for IDLE.
        push_expect(0, tbl[1]);
        drive_fields(0, tbl[1]);
        accept(0, 1'b1);
        drive_fields(0, tbl[11]);
        wait_done(0, tbl[1].lat, 1'b0, 16'h1BCD, "b2b_first");
        push_expect(0, tbl[11]);
        @(posedge clk);
        #1;
        cmd_valid[0] = 1'b0;
        scramble(0);
        wait_done(0, tbl[11].lat, 1'b0, 16'h1BCD, "b2b_second");

        push_expect(1, d1a);
        drive_fields(1, d1a);
        accept(1, 1'b0);
        wait_done(1, d1a.lat, 1'b0, 16'h0000, "slow_prog");
        push_expect(1, d1b);
        drive_fields(1, d1b);
        accept(1, 1'b0);
        wait_done(1, d1b.lat, 1'b0, 16'h4321, "slow_read");

        // Reset during the strobe of the second count byte.
        push_expect(0, tbl[0]);
        drive_fields(0, tbl[0]);
        accept(0, 1'b0);
        nwr = 0;
        hit = 1'b0;
        prev_wr = 1'b1;
        for (int i = 0; (i < 40) && !hit; i++) begin
            @(negedge clk);
            if (!pit_wr_n[0] && prev_wr) nwr++;
            prev_wr = pit_wr_n[0];
            if (nwr == 3) hit = 1'b1;
        end
        check("rst_reached_b1_strobe", hit, 1);
        exp_q[0].delete();
        feed_q[0].delete();
        abort[0] = 1'b1;
        rst[0] = 1'b1;
        @(negedge clk);
        check("rst_bus_idle", {pit_wr_n[0], pit_rd_n[0], pit_cs_n[0], pit_d_oe[0], done[0]}, 5'b11100);
        check("rst_rd_count", rd_count[0], 16'h0000);
        rst[0] = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done[0]) seen_done = 1'b1;
        end
        check("rst_no_done", seen_done, 0);
        check("rst_ready", {cmd_ready[0], pit_cs_n[0]}, 2'b11);

        check("no_rd_wr_overlap", overlap_seen, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
